// File: rtl/m_stopwatch.sv
// m_stopwatch -- parametrised multi-digit BCD stopwatch/timer.
//
// A two-stage prescaler (p: 0..PRE_DIV-1, q: 0..TICK_DIV-1) feeds a
// DIGITS-wide BCD counter that counts up or down, with run/pause/clear control,
// BCD preload and a one-hot decode of digit 0.
// The count period is PRE_DIV*TICK_DIV clk cycles.
//
// Optional feature macro: M_STOPWATCH_ALARM_EN. This adds the alarm_val
// input and a sticky alarm output. When the count reaches alarm_val, the alarm
// is set and the block pauses.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start/stop/clear  run control (priority rst > clear > load_en > stop > start)
//   down              0 = count up, 1 = count down
//   load_en/load_val  BCD preload (digits > 9 load as 0)
//   bcd               registered count, digit 0 in [3:0]
//   sec               one-hot decode of digit 0
//   tick/wrap         one-cycle pulses aligned with a new bcd value
//   running           high while in RUN
//   alarm_val/alarm   (alarm build only) compare value and sticky alarm flag
module m_stopwatch #(
  parameter int PRE_DIV  = 50000,
  parameter int TICK_DIV = 100,
  parameter int DIGITS   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic                  down,
  input  logic                  load_en,
  input  logic [4*DIGITS-1:0]   load_val,
`ifdef M_STOPWATCH_ALARM_EN
  input  logic [4*DIGITS-1:0]   alarm_val,
  output logic                  alarm,
`endif
  output logic [4*DIGITS-1:0]   bcd,
  output logic [9:0]            sec,
  output logic                  tick,
  output logic                  wrap,
  output logic                  running
);

  localparam int DW = 4 * DIGITS;
  localparam int PW = $clog2(PRE_DIV);
  localparam int QW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] P_MAX = PW'(PRE_DIV - 1);
  localparam logic [QW-1:0] Q_MAX = QW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;

  state_t        state;
  logic [PW-1:0] p;
  logic [QW-1:0] q;
  logic          c1, upd;
  logic [DW-1:0] bcd_nxt, load_bcd;
  logic          wrap_nxt;

  assign c1      = (state == RUN) && (p == P_MAX);
  assign upd     = c1 && (q == Q_MAX);
  assign running = (state == RUN);

  // Ripple BCD increment/decrement. The carry out of the top digit marks a wrap.
  always_comb begin
    logic       carry;
    logic [3:0] dig;
    carry   = 1'b1;
    dig     = 4'd0;
    bcd_nxt = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      dig = bcd[4*i +: 4];
      if (carry) begin
        if (!down) begin
          if (dig >= 4'd9) dig = 4'd0;
          else begin dig = dig + 4'd1; carry = 1'b0; end
        end else begin
          if (dig == 4'd0) dig = 4'd9;
          else begin dig = dig - 4'd1; carry = 1'b0; end
        end
      end
      bcd_nxt[4*i +: 4] = dig;
    end
    wrap_nxt = carry;
  end

  // Preload value with non-decimal digits forced to 0.
  always_comb begin
    load_bcd = '0;
    for (int i = 0; i < DIGITS; i++)
      load_bcd[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd0 : load_val[4*i +: 4];
  end

  always_comb begin
    sec = '0;
    for (int n = 0; n < 10; n++)
      sec[n] = (bcd[3:0] == 4'(n));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      p     <= '0;
      q     <= '0;
      bcd   <= '0;
      tick  <= 1'b0;
      wrap  <= 1'b0;
`ifdef M_STOPWATCH_ALARM_EN
      alarm <= 1'b0;
`endif
    end else begin
      tick <= 1'b0;
      wrap <= 1'b0;
      if (clear) begin
        state <= IDLE;
        p     <= '0;
        q     <= '0;
        bcd   <= '0;
`ifdef M_STOPWATCH_ALARM_EN
        alarm <= 1'b0;
`endif
      end else if (load_en) begin
        // Restart the period from the preload. The state is left unchanged.
        p     <= '0;
        q     <= '0;
        bcd   <= load_bcd;
`ifdef M_STOPWATCH_ALARM_EN
        alarm <= 1'b0;
`endif
      end else begin
        // Prescaler. PAUSED holds p/q so that a resume keeps the sub-period phase.
        if (state == RUN) begin
          p <= (p == P_MAX) ? '0 : p + 1'b1;
          if (c1) q <= (q == Q_MAX) ? '0 : q + 1'b1;
        end else if (state == IDLE) begin
          p <= '0;
          q <= '0;
        end

        // A stop in the same cycle as a start takes priority over it.
        case (state)
          IDLE:    if (start && !stop) state <= RUN;
          RUN:     if (stop)           state <= PAUSED;
          PAUSED:  if (start && !stop) state <= RUN;
          default:                     state <= IDLE;
        endcase

        if (upd) begin
          bcd  <= bcd_nxt;
          tick <= 1'b1;
          wrap <= wrap_nxt;
`ifdef M_STOPWATCH_ALARM_EN
          if (bcd_nxt == alarm_val) begin
            alarm <= 1'b1;
            state <= PAUSED;
          end
`endif
        end
      end
    end
  end

endmodule
